rsa_engine_ctrl: RTL and testbench

Parametrised command/response sequencer for the RSA datapath: the successor to the fixed-width mode-driven top-level controller. It accepts one command per valid/ready handshake, latches all operands, and validates mode and arguments. It derives the exponent MSB index at run time instead of using hardcoded lengths, then sequences either the key-generator or the Montgomery-exponentiation engine through clear/start/done. It adds timeout, abort and error status, and returns results on a held valid/ready response channel.

---
 rtl/rsa_engine_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_rsa_engine_ctrl.sv | 536 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_engine_ctrl.sv
// rsa_engine_ctrl: command/response sequencer for the RSA keygen and
// exponentiation engines, with argument checks, timeout and abort.
module rsa_engine_ctrl #(
   parameter int WORD_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_mode,
   input  logic [WORD_WIDTH/2-1:0]       cmd_seed,
   input  logic [WORD_WIDTH-1:0]         cmd_msg,
   input  logic [WORD_WIDTH-1:0]         cmd_exp,
   input  logic [WORD_WIDTH-1:0]         cmd_mod,
   input  logic                          abort,
   output logic                          busy,
   output logic                          kg_rst,
   output logic                          kg_start,
   output logic [WORD_WIDTH/2-1:0]       kg_seed,
   input  logic                          kg_done,
   input  logic [WORD_WIDTH-1:0]         kg_e,
   input  logic [WORD_WIDTH-1:0]         kg_d,
   input  logic [WORD_WIDTH-1:0]         kg_n,
   output logic                          me_rst,
   output logic                          me_start,
   output logic [WORD_WIDTH-1:0]         me_base,
   output logic [WORD_WIDTH-1:0]         me_exp,
   output logic [WORD_WIDTH-1:0]         me_mod,
   output logic [$clog2(WORD_WIDTH)-1:0] me_t,
   input  logic                          me_done,
   input  logic [WORD_WIDTH-1:0]         me_result,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [2:0]                    rsp_status,
   output logic [WORD_WIDTH-1:0]         rsp_msg,
   output logic [WORD_WIDTH-1:0]         rsp_e,
   output logic [WORD_WIDTH-1:0]         rsp_d,
   output logic [WORD_WIDTH-1:0]         rsp_n
);

   localparam int HW = WORD_WIDTH / 2;
   localparam int TW = $clog2(WORD_WIDTH);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] ST_OK      = 3'd0;
   localparam logic [2:0] ST_ERRMODE = 3'd1;
   localparam logic [2:0] ST_ERRARG  = 3'd2;
   localparam logic [2:0] ST_TIMEOUT = 3'd3;
   localparam logic [2:0] ST_ABORTED = 3'd4;

   typedef enum logic [2:0] {
      IDLE,
      KG_CLR,
      KG_RUN,
      ME_CLR,
      ME_RUN,
      RESP
   } state_t;

   state_t          state_q;
   logic            cmd_ready_q;
   logic            busy_q;
   logic            kg_rst_q;
   logic            kg_start_q;
   logic            me_rst_q;
   logic            me_start_q;
   logic [HW-1:0]   seed_q;
   logic [WORD_WIDTH-1:0] base_q;
   logic [WORD_WIDTH-1:0] exp_q;
   logic [WORD_WIDTH-1:0] mod_q;
   logic [TW-1:0]   me_t_q;
   logic [CW-1:0]   cnt_q;
   logic            rsp_valid_q;
   logic [2:0]      status_q;
   logic [WORD_WIDTH-1:0] msg_q;
   logic [WORD_WIDTH-1:0] e_q;
   logic [WORD_WIDTH-1:0] d_q;
   logic [WORD_WIDTH-1:0] n_q;

   function automatic logic [TW-1:0] msb_idx(
      input logic [WORD_WIDTH-1:0] v
   );
      logic [TW-1:0] r;
      r = '0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         if (v[i]) r = TW'(i);
      end
      return r;
   endfunction

   logic          accept;
   logic          mode_none;
   logic          mode_kg;
   logic          arg_bad;
   logic          run_kg;
   logic          run_done;
   logic [TW-1:0] me_t_d;

   assign accept    = cmd_valid & cmd_ready_q;
   assign mode_none = (cmd_mode == 2'b00);
   assign mode_kg   = (cmd_mode == 2'b01);
   assign arg_bad   = (cmd_exp == '0) | ~cmd_mod[0]
                    | (cmd_mod < WORD_WIDTH'(3));
   assign run_kg    = (state_q == KG_RUN);
   assign run_done  = run_kg ? kg_done : me_done;
   assign me_t_d    = msb_idx(exp_q);

   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;
   assign kg_rst     = kg_rst_q;
   assign kg_start   = kg_start_q;
   assign kg_seed    = seed_q;
   assign me_rst     = me_rst_q;
   assign me_start   = me_start_q;
   assign me_base    = base_q;
   assign me_exp     = exp_q;
   assign me_mod     = mod_q;
   assign me_t       = me_t_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_status = status_q;
   assign rsp_msg    = msg_q;
   assign rsp_e      = e_q;
   assign rsp_d      = d_q;
   assign rsp_n      = n_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         kg_rst_q    <= 1'b1;
         kg_start_q  <= 1'b0;
         me_rst_q    <= 1'b1;
         me_start_q  <= 1'b0;
         seed_q      <= '0;
         base_q      <= '0;
         exp_q       <= '0;
         mod_q       <= '0;
         me_t_q      <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         status_q    <= ST_OK;
         msg_q       <= '0;
         e_q         <= '0;
         d_q         <= '0;
         n_q         <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               kg_rst_q    <= 1'b0;
               me_rst_q    <= 1'b0;
               cmd_ready_q <= 1'b1;
               if (accept) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  seed_q      <= cmd_seed;
                  base_q      <= cmd_msg;
                  exp_q       <= cmd_exp;
                  mod_q       <= cmd_mod;
                  unique case (1'b1)
                     mode_none: begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        status_q    <= ST_ERRMODE;
                        msg_q       <= '0;
                        e_q         <= '0;
                        d_q         <= '0;
                        n_q         <= '0;
                     end
                     mode_kg: begin
                        state_q  <= KG_CLR;
                        kg_rst_q <= 1'b1;
                     end
                     cmd_mode[1] & arg_bad: begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        status_q    <= ST_ERRARG;
                        msg_q       <= '0;
                        e_q         <= '0;
                        d_q         <= '0;
                        n_q         <= '0;
                     end
                     cmd_mode[1] & ~arg_bad: begin
                        state_q  <= ME_CLR;
                        me_rst_q <= 1'b1;
                     end
                     default: state_q <= IDLE;
                  endcase
               end
            end
            KG_CLR: begin
               state_q    <= KG_RUN;
               kg_rst_q   <= 1'b0;
               kg_start_q <= 1'b1;
               me_t_q     <= me_t_d;
               cnt_q      <= '0;
            end
            ME_CLR: begin
               state_q    <= ME_RUN;
               me_rst_q   <= 1'b0;
               me_start_q <= 1'b1;
               me_t_q     <= me_t_d;
               cnt_q      <= '0;
            end
            KG_RUN, ME_RUN: begin
               // done wins over abort, abort wins over timeout
               if (run_done) begin
                  state_q     <= RESP;
                  kg_start_q  <= 1'b0;
                  me_start_q  <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  status_q    <= ST_OK;
                  msg_q       <= run_kg ? '0 : me_result;
                  e_q         <= run_kg ? kg_e : '0;
                  d_q         <= run_kg ? kg_d : '0;
                  n_q         <= run_kg ? kg_n : '0;
               end else if (abort || cnt_q == CNT_LAST) begin
                  state_q     <= RESP;
                  kg_start_q  <= 1'b0;
                  me_start_q  <= 1'b0;
                  kg_rst_q    <= run_kg;
                  me_rst_q    <= ~run_kg;
                  rsp_valid_q <= 1'b1;
                  status_q    <= abort ? ST_ABORTED : ST_TIMEOUT;
                  msg_q       <= '0;
                  e_q         <= '0;
                  d_q         <= '0;
                  n_q         <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RESP: begin
               kg_rst_q <= 1'b0;
               me_rst_q <= 1'b0;
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_engine_ctrl.sv
// tb_rsa_engine_ctrl: randomized and directed checks of the RSA sequencer
// against behavioural engine models and a rule-level reference.
module tb_rsa_engine_ctrl;

   localparam int W  = 32;
   localparam int TO = 128;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_mode;
   logic [W/2-1:0] cmd_seed;
   logic [W-1:0]  cmd_msg;
   logic [W-1:0]  cmd_exp;
   logic [W-1:0]  cmd_mod;
   logic          abort;
   logic          busy;
   logic          kg_rst;
   logic          kg_start;
   logic [W/2-1:0] kg_seed;
   logic          kg_done;
   logic [W-1:0]  kg_e;
   logic [W-1:0]  kg_d;
   logic [W-1:0]  kg_n;
   logic          me_rst;
   logic          me_start;
   logic [W-1:0]  me_base;
   logic [W-1:0]  me_exp;
   logic [W-1:0]  me_mod;
   logic [4:0]    me_t;
   logic          me_done;
   logic [W-1:0]  me_result;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [2:0]    rsp_status;
   logic [W-1:0]  rsp_msg;
   logic [W-1:0]  rsp_e;
   logic [W-1:0]  rsp_d;
   logic [W-1:0]  rsp_n;

   int n_checks = 0;
   int n_fail   = 0;

   int me_lat = 0;
   int kg_lat = 0;
   int me_cnt = 0;
   int kg_cnt = 0;
   int me_start_cyc = 0;
   int me_rst_cyc   = 0;
   int kg_start_cyc = 0;
   int kg_rst_cyc   = 0;

   rsa_engine_ctrl #(
      .WORD_WIDTH    (W),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_seed  (cmd_seed),
      .cmd_msg   (cmd_msg),
      .cmd_exp   (cmd_exp),
      .cmd_mod   (cmd_mod),
      .abort     (abort),
      .busy      (busy),
      .kg_rst    (kg_rst),
      .kg_start  (kg_start),
      .kg_seed   (kg_seed),
      .kg_done   (kg_done),
      .kg_e      (kg_e),
      .kg_d      (kg_d),
      .kg_n      (kg_n),
      .me_rst    (me_rst),
      .me_start  (me_start),
      .me_base   (me_base),
      .me_exp    (me_exp),
      .me_mod    (me_mod),
      .me_t      (me_t),
      .me_done   (me_done),
      .me_result (me_result),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_status(rsp_status),
      .rsp_msg   (rsp_msg),
      .rsp_e     (rsp_e),
      .rsp_d     (rsp_d),
      .rsp_n     (rsp_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] modexp(
      input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m
   );
      longint unsigned r, x, mm;
      if (m == 0) return '0;
      mm = 64'(m);
      r  = 64'd1 % mm;
      x  = 64'(b) % mm;
      for (int i = 0; i < W; i++) begin
         if (e[i]) r = (r * x) % mm;
         x = (x * x) % mm;
      end
      return r[W-1:0];
   endfunction

   function automatic int ref_msb(input logic [W-1:0] v);
      int t = 0;
      logic [W-1:0] x = v;
      while (x > 1) begin
         x = x >> 1;
         t++;
      end
      return t;
   endfunction

   // engines: done is raised in the Nth cycle that start is held high
   always @(negedge clk) begin
      if (me_start) me_cnt = me_cnt + 1;
      else me_cnt = 0;
      if (kg_start) kg_cnt = kg_cnt + 1;
      else kg_cnt = 0;
      me_done   = me_start && me_lat > 0 && me_cnt == me_lat;
      kg_done   = kg_start && kg_lat > 0 && kg_cnt == kg_lat;
      me_result = me_start ? modexp(me_base, me_exp, me_mod) : '0;
      if (me_start) me_start_cyc++;
      if (me_rst)   me_rst_cyc++;
      if (kg_start) kg_start_cyc++;
      if (kg_rst)   kg_rst_cyc++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(
      input logic [1:0] mode, input logic [W/2-1:0] seed,
      input logic [W-1:0] msg, input logic [W-1:0] ex,
      input logic [W-1:0] md, input int abort_k, output int lat
   );
      cmd_mode  = mode;
      cmd_seed  = seed;
      cmd_msg   = msg;
      cmd_exp   = ex;
      cmd_mod   = md;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 2000) begin
         abort = (abort_k >= 0 && lat == abort_k + 1);
         tick;
         lat++;
      end
      abort = 1'b0;
   endtask

   task automatic consume;
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (kg_rst !== 1'b1 || me_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_rst: kg_rst=%b me_rst=%b want 1 1", kg_rst, me_rst);
      end
      n_checks++;
      if ({cmd_ready, rsp_valid, busy, kg_start, me_start} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outs: rdy=%b vld=%b busy=%b kgs=%b mes=%b want 0",
                  cmd_ready, rsp_valid, busy, kg_start, me_start);
      end
      rst_n = 1'b1;
      tick;
      n_checks++;
      if (cmd_ready !== 1'b1 || kg_rst !== 1'b0 || me_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: rdy=%b kg_rst=%b me_rst=%b want 1 0 0",
                  cmd_ready, kg_rst, me_rst);
      end
   endtask

   task automatic test_encrypt;
      int lat, s0, r0, k0;
      me_lat = 40;
      s0 = me_start_cyc;
      r0 = me_rst_cyc;
      k0 = kg_start_cyc;
      issue(2'b10, '0, 65, 17, 3233, -1, lat);
      n_checks++;
      if (lat != 42) begin
         n_fail++;
         $display("FAIL enc_latency: got %0d want 42", lat);
      end
      n_checks++;
      if (rsp_status !== 3'd0 || rsp_msg !== 32'd2790) begin
         n_fail++;
         $display("FAIL enc_result: status=%0d msg=%0d want 0 2790",
                  rsp_status, rsp_msg);
      end
      n_checks++;
      if (me_t !== 5'd4) begin
         n_fail++;
         $display("FAIL enc_me_t: got %0d want 4", me_t);
      end
      n_checks++;
      if (me_start_cyc - s0 != 40 || me_rst_cyc - r0 != 1
          || kg_start_cyc != k0) begin
         n_fail++;
         $display("FAIL enc_engine: start=%0d rst=%0d kgstart=%0d want 40 1 0",
                  me_start_cyc - s0, me_rst_cyc - r0, kg_start_cyc - k0);
      end
      n_checks++;
      if (rsp_e !== '0 || rsp_d !== '0 || rsp_n !== '0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL enc_fields: e=%0d d=%0d n=%0d busy=%b want 0 0 0 1",
                  rsp_e, rsp_d, rsp_n, busy);
      end
      consume;
      n_checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL enc_handshake: vld=%b rdy=%b busy=%b want 0 1 0",
                  rsp_valid, cmd_ready, busy);
      end
   endtask

   task automatic test_decrypt;
      int lat;
      me_lat = 25;
      issue(2'b11, '0, 2790, 2753, 3233, -1, lat);
      n_checks++;
      if (rsp_status !== 3'd0 || rsp_msg !== 32'd65 || lat != 27) begin
         n_fail++;
         $display("FAIL dec_result: status=%0d msg=%0d lat=%0d want 0 65 27",
                  rsp_status, rsp_msg, lat);
      end
      n_checks++;
      if (me_t !== 5'd11) begin
         n_fail++;
         $display("FAIL dec_me_t: got %0d want 11", me_t);
      end
      for (int i = 0; i < 5; i++) begin
         tick;
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_status !== 3'd0 || rsp_msg !== 32'd65) begin
            n_fail++;
            $display("FAIL dec_hold%0d: vld=%b status=%0d msg=%0d want 1 0 65",
                     i, rsp_valid, rsp_status, rsp_msg);
         end
      end
      consume;
   endtask

   task automatic test_keygen;
      int lat, r0, s0, m0;
      kg_lat = 100;
      kg_e   = 17;
      kg_d   = 2753;
      kg_n   = 3233;
      r0 = kg_rst_cyc;
      s0 = kg_start_cyc;
      m0 = me_start_cyc;
      issue(2'b01, 16'h1234, '0, '0, '0, -1, lat);
      n_checks++;
      if (kg_seed !== 16'h1234 || lat != 102) begin
         n_fail++;
         $display("FAIL kg_seed_lat: seed=%h lat=%0d want 1234 102", kg_seed, lat);
      end
      n_checks++;
      if (rsp_status !== 3'd0 || rsp_e !== 32'd17 || rsp_d !== 32'd2753
          || rsp_n !== 32'd3233 || rsp_msg !== '0) begin
         n_fail++;
         $display("FAIL kg_result: st=%0d e=%0d d=%0d n=%0d msg=%0d",
                  rsp_status, rsp_e, rsp_d, rsp_n, rsp_msg);
      end
      n_checks++;
      if (kg_rst_cyc - r0 != 1 || kg_start_cyc - s0 != 100
          || me_start_cyc != m0) begin
         n_fail++;
         $display("FAIL kg_engine: rst=%0d start=%0d mestart=%0d want 1 100 0",
                  kg_rst_cyc - r0, kg_start_cyc - s0, me_start_cyc - m0);
      end
      consume;
   endtask

   task automatic test_errors;
      logic [1:0]   md[4]  = '{2'b00, 2'b10, 2'b10, 2'b11};
      logic [W-1:0] ex[4]  = '{32'd17, 32'd17, 32'd0, 32'd5};
      logic [W-1:0] mo[4]  = '{32'd3233, 32'd3232, 32'd3233, 32'd1};
      logic [2:0]   st[4]  = '{3'd1, 3'd2, 3'd2, 3'd2};
      for (int i = 0; i < 4; i++) begin
         int lat, ms, ks, mr, kr;
         ms = me_start_cyc;
         ks = kg_start_cyc;
         mr = me_rst_cyc;
         kr = kg_rst_cyc;
         issue(md[i], 16'h55, 32'd9, ex[i], mo[i], -1, lat);
         n_checks++;
         if (lat != 1 || rsp_status !== st[i] || rsp_msg !== '0) begin
            n_fail++;
            $display("FAIL err%0d: lat=%0d status=%0d msg=%0d want 1 %0d 0",
                     i, lat, rsp_status, rsp_msg, st[i]);
         end
         tick;
         n_checks++;
         if (me_start_cyc != ms || kg_start_cyc != ks
             || me_rst_cyc != mr || kg_rst_cyc != kr) begin
            n_fail++;
            $display("FAIL err%0d_engine: engine activity on error command", i);
         end
         consume;
      end
   endtask

   task automatic test_timeout_abort;
      int lat, r0;
      me_lat = 0;
      r0 = me_rst_cyc;
      issue(2'b10, '0, 7, 3, 11, -1, lat);
      n_checks++;
      if (rsp_status !== 3'd3 || lat != TO + 2 || me_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout: status=%0d lat=%0d me_rst=%b want 3 %0d 1",
                  rsp_status, lat, me_rst, TO + 2);
      end
      tick;
      n_checks++;
      if (me_rst !== 1'b0 || me_rst_cyc - r0 != 2 || me_start !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_rst: me_rst=%b pulses=%0d start=%b want 0 2 0",
                  me_rst, me_rst_cyc - r0, me_start);
      end
      consume;
      me_lat = TO;
      issue(2'b10, '0, 7, 3, 11, -1, lat);
      n_checks++;
      if (rsp_status !== 3'd0 || rsp_msg !== 32'd2) begin
         n_fail++;
         $display("FAIL done_at_limit: status=%0d msg=%0d want 0 2",
                  rsp_status, rsp_msg);
      end
      consume;
      me_lat = 10;
      issue(2'b10, '0, 7, 3, 11, 10, lat);
      n_checks++;
      if (rsp_status !== 3'd0 || lat != 12) begin
         n_fail++;
         $display("FAIL abort_with_done: status=%0d lat=%0d want 0 12",
                  rsp_status, lat);
      end
      consume;
      me_lat = 0;
      issue(2'b10, '0, 7, 3, 11, 5, lat);
      n_checks++;
      if (rsp_status !== 3'd4 || lat != 7 || me_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL abort: status=%0d lat=%0d me_rst=%b want 4 7 1",
                  rsp_status, lat, me_rst);
      end
      consume;
      kg_lat = 0;
      issue(2'b01, 16'h1, '0, '0, '0, 3, lat);
      n_checks++;
      if (rsp_status !== 3'd4 || kg_rst !== 1'b1 || rsp_e !== '0) begin
         n_fail++;
         $display("FAIL kg_abort: status=%0d kg_rst=%b e=%0d want 4 1 0",
                  rsp_status, kg_rst, rsp_e);
      end
      consume;
      me_lat = 3;
      issue(2'b10, '0, 7, 3, 11, 0, lat);
      n_checks++;
      if (rsp_status !== 3'd0 || lat != 5) begin
         n_fail++;
         $display("FAIL abort_in_clr: status=%0d lat=%0d want 0 5",
                  rsp_status, lat);
      end
      consume;
   endtask

   task automatic test_random;
      for (int it = 0; it < 30; it++) begin
         logic [1:0]   mode;
         logic [W-1:0] msg, ex, md, em, ee, ed, en;
         logic [15:0]  seed;
         int ak, n, fin, lat, elat, est, k;
         mode = 2'($urandom_range(0, 3));
         msg  = $urandom;
         md   = 32'($urandom_range(0, 5000));
         if ($urandom_range(0, 3) != 0) md[0] = 1'b1;
         ex   = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
         seed = 16'($urandom);
         me_lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
         kg_lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
         kg_e = $urandom;
         kg_d = $urandom;
         kg_n = $urandom;
         ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : -1;
         em = '0; ee = '0; ed = '0; en = '0;
         if (mode == 2'b00) begin
            est = 1; elat = 1;
         end else if (mode[1] && (ex == 0 || md % 2 == 0 || md < 3)) begin
            est = 2; elat = 1;
         end else begin
            n = (mode == 2'b01) ? kg_lat : me_lat;
            if (n == 0) n = TO + 1;
            k = (ak >= 1) ? ak : TO + 1;
            if (n <= k && n <= TO) begin
               est = 0; fin = n;
               if (mode == 2'b01) begin
                  ee = kg_e; ed = kg_d; en = kg_n;
               end else begin
                  em = modexp(msg, ex, md);
               end
            end else if (k <= TO) begin
               est = 4; fin = k;
            end else begin
               est = 3; fin = TO;
            end
            elat = fin + 2;
         end
         issue(mode, seed, msg, ex, md, ak, lat);
         n_checks++;
         if (rsp_status !== 3'(est) || lat != elat) begin
            n_fail++;
            $display("FAIL rnd%0d_status: st=%0d lat=%0d want %0d %0d mode=%0d",
                     it, rsp_status, lat, est, elat, mode);
         end
         n_checks++;
         if (rsp_msg !== em || rsp_e !== ee || rsp_d !== ed || rsp_n !== en) begin
            n_fail++;
            $display("FAIL rnd%0d_data: msg=%h e=%h d=%h n=%h want %h %h %h %h",
                     it, rsp_msg, rsp_e, rsp_d, rsp_n, em, ee, ed, en);
         end
         if (mode[1] && est == 0) begin
            n_checks++;
            if (me_t !== 5'(ref_msb(ex))) begin
               n_fail++;
               $display("FAIL rnd%0d_me_t: got %0d want %0d",
                        it, me_t, ref_msb(ex));
            end
         end
         consume;
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      me_lat = 0;
      cmd_mode  = 2'b10;
      cmd_msg   = 65;
      cmd_exp   = 17;
      cmd_mod   = 3233;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      repeat (5) tick;
      n_checks++;
      if (me_start !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_running: start=%b busy=%b want 1 1", me_start, busy);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (me_rst !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0
          || me_start !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: rst=%b vld=%b rdy=%b start=%b want 1 0 0 0",
                  me_rst, rsp_valid, cmd_ready, me_start);
      end
      tick;
      tick;
      n_checks++;
      if (me_rst !== 1'b1 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_hold: rst=%b rdy=%b vld=%b want 1 0 0",
                  me_rst, cmd_ready, rsp_valid);
      end
      rst_n = 1'b1;
      tick;
      n_checks++;
      if (cmd_ready !== 1'b1 || me_rst !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_release: rdy=%b rst=%b vld=%b want 1 0 0",
                  cmd_ready, me_rst, rsp_valid);
      end
      me_lat = 40;
      issue(2'b10, '0, 65, 17, 3233, -1, lat);
      n_checks++;
      if (rsp_status !== 3'd0 || rsp_msg !== 32'd2790 || lat != 42) begin
         n_fail++;
         $display("FAIL mid_after: st=%0d msg=%0d lat=%0d want 0 2790 42",
                  rsp_status, rsp_msg, lat);
      end
      consume;
   endtask

   initial begin
      cmd_valid = 1'b0;
      cmd_mode  = '0;
      cmd_seed  = '0;
      cmd_msg   = '0;
      cmd_exp   = '0;
      cmd_mod   = '0;
      abort     = 1'b0;
      rsp_ready = 1'b0;
      kg_e      = '0;
      kg_d      = '0;
      kg_n      = '0;
      test_reset;
      test_encrypt;
      test_decrypt;
      test_keygen;
      test_errors;
      test_timeout_abort;
      test_random;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
